// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
//   DATA_W_DEF / ADDR_W_DEF : default register width and address width
//   ZERO_REG                : hard-wired zero register index
//   rd_slice(idx, w)        : LSB offset of field idx in a packed port vector
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_REG   = 0;

  function automatic int rd_slice(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read path of the register file.
//   i_rst            : reset in progress (bypass is disabled while high)
//   i_ra             : read address
//   i_mem_flat       : flattened register contents, register k at [k*DATA_W +: DATA_W]
//   i_busy           : per-register busy bits (registered)
//   i_we0/i_wr0/i_d0 : write port 0 (bypass source, lower priority)
//   i_we1/i_wr1/i_d1 : write port 1 (bypass source, higher priority)
//   o_q              : read data
//   o_busy           : busy bit of the addressed register
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic                             i_rst,
  input  logic [ADDR_W-1:0]                i_ra,
  input  logic [(2**ADDR_W)*DATA_W-1:0]    i_mem_flat,
  input  logic [(2**ADDR_W)-1:0]           i_busy,
  input  logic                             i_we0,
  input  logic [ADDR_W-1:0]                i_wr0,
  input  logic [DATA_W-1:0]                i_d0,
  input  logic                             i_we1,
  input  logic [ADDR_W-1:0]                i_wr1,
  input  logic [DATA_W-1:0]                i_d1,
  output logic [DATA_W-1:0]                o_q,
  output logic                             o_busy
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] w_stored;
  logic              w_byp_en;

  assign w_stored = i_mem_flat[int'(i_ra) * DATA_W +: DATA_W];
  assign w_byp_en = (BYPASS != 0) && !i_rst;

  // Port 1 wins over port 0, matching the storage priority on collisions.
  always_comb begin
    o_q = w_stored;
    if (i_ra == ZERO_A) begin
      o_q = '0;
    end else if (w_byp_en && i_we1 && (i_wr1 == i_ra)) begin
      o_q = i_d1;
    end else if (w_byp_en && i_we0 && (i_wr0 == i_ra)) begin
      o_q = i_d0;
    end
  end

  assign o_busy = i_busy[i_ra];

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write bypass and busy scoreboard.
//   Clk, Rst          : clock, synchronous active-high reset
//   We0/Wr0/D0        : write port 0
//   We1/Wr1/D1        : write port 1 (wins on same-address collision)
//   Ra / Q            : packed read addresses / read data, NUM_RD ports
//   Set_en / Set_addr : mark a register busy (producer issued)
//   Busy_rd           : busy flag per read port
//   Busy_any          : OR of all busy bits
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     We0,
  input  logic [ADDR_W-1:0]        Wr0,
  input  logic [DATA_W-1:0]        D0,
  input  logic                     We1,
  input  logic [ADDR_W-1:0]        Wr1,
  input  logic [DATA_W-1:0]        D1,
  input  logic [NUM_RD*ADDR_W-1:0] Ra,
  output logic [NUM_RD*DATA_W-1:0] Q,
  input  logic                     Set_en,
  input  logic [ADDR_W-1:0]        Set_addr,
  output logic [NUM_RD-1:0]        Busy_rd,
  output logic                     Busy_any
);

  localparam int                DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp_sb: NUM_RD must be in 1..4");
  end

  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [DEPTH-1:0]        r_busy_reg;
  logic [DEPTH-1:0]        w_busy_next;
  logic [DEPTH*DATA_W-1:0] w_mem_flat;
  logic                    w_we0_ok;
  logic                    w_we1_ok;
  logic                    w_set_ok;

  assign w_we0_ok = We0 && (Wr0 != ZERO_A);
  assign w_we1_ok = We1 && (Wr1 != ZERO_A);
  assign w_set_ok = Set_en && (Set_addr != ZERO_A);

  // Port 1 is assigned last so it overrides port 0 on a shared address.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_we0_ok) r_mem[Wr0] <= D0;
      if (w_we1_ok) r_mem[Wr1] <= D1;
    end
  end

  // Retiring writes clear, then issue sets: a new producer supersedes the old one.
  always_comb begin
    w_busy_next = r_busy_reg;
    if (w_we0_ok) w_busy_next[Wr0] = 1'b0;
    if (w_we1_ok) w_busy_next[Wr1] = 1'b0;
    if (w_set_ok) w_busy_next[Set_addr] = 1'b1;
    w_busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_busy_reg <= '0;
    end else begin
      r_busy_reg <= w_busy_next;
    end
  end

  assign Busy_any = |r_busy_reg;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
    assign w_mem_flat[gi*DATA_W +: DATA_W] = r_mem[gi];
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS)
    ) u_rd (
      .i_rst      (Rst),
      .i_ra       (Ra[rd_slice(gi, ADDR_W) +: ADDR_W]),
      .i_mem_flat (w_mem_flat),
      .i_busy     (r_busy_reg),
      .i_we0      (We0),
      .i_wr0      (Wr0),
      .i_d0       (D0),
      .i_we1      (We1),
      .i_wr1      (Wr1),
      .i_d1       (D1),
      .o_q        (Q[rd_slice(gi, DATA_W) +: DATA_W]),
      .o_busy     (Busy_rd[gi])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed test of regfile_mp_sb. Two instances share all
// stimulus: u_nb with BYPASS=0 and u_bp with BYPASS=1.
module tb_regfile_mp_sb;

  logic        clk;
  logic        rst;
  logic        we0, we1, set_en;
  logic [4:0]  wr0, wr1, set_addr;
  logic [31:0] d0, d1;
  logic [9:0]  ra;
  logic [63:0] q_nb, q_bp;
  logic [1:0]  busy_nb, busy_bp;
  logic        any_nb, any_bp;

  int errors = 0;
  int checks = 0;

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) u_nb (
    .Clk(clk), .Rst(rst), .We0(we0), .Wr0(wr0), .D0(d0),
    .We1(we1), .Wr1(wr1), .D1(d1), .Ra(ra), .Q(q_nb),
    .Set_en(set_en), .Set_addr(set_addr), .Busy_rd(busy_nb), .Busy_any(any_nb)
  );

  regfile_mp_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) u_bp (
    .Clk(clk), .Rst(rst), .We0(we0), .Wr0(wr0), .D0(d0),
    .We1(we1), .Wr1(wr1), .D1(d1), .Ra(ra), .Q(q_bp),
    .Set_en(set_en), .Set_addr(set_addr), .Busy_rd(busy_bp), .Busy_any(any_bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance through one rising edge; inputs may change 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; set_en = 0;
    wr0 = '0; wr1 = '0; set_addr = '0;
    d0 = '0; d1 = '0;
  endtask

  initial begin
    rst = 1; idle(); ra = '0;
    tick();
    rst = 0;

    // Reset then read: r5 holds 0xDEAD before a reset edge
    we0 = 1; wr0 = 5; d0 = 32'hDEAD; ra = {5'd0, 5'd5};
    tick();
    idle(); settle();
    chk("pre_rst_r5_nb", q_nb[31:0], 32'hDEAD);
    rst = 1; we0 = 1; wr0 = 5; d0 = 32'h1111; settle();
    chk("rst_bypass_off_bp", q_bp[31:0], 32'hDEAD);
    tick();
    rst = 0; idle(); settle();
    chk("post_rst_r5_nb", q_nb[31:0], 32'h0);
    chk("post_rst_r5_bp", q_bp[31:0], 32'h0);
    chk("post_rst_any_nb", any_nb, 1'b0);
    chk("post_rst_any_bp", any_bp, 1'b0);

    // Write then read with and without bypass
    we0 = 1; wr0 = 3; d0 = 32'h1234; ra = {5'd0, 5'd3}; settle();
    chk("wr3_same_nb", q_nb[31:0], 32'h0);
    chk("wr3_same_bp", q_bp[31:0], 32'h1234);
    tick();
    idle(); settle();
    chk("wr3_next_nb", q_nb[31:0], 32'h1234);

    // Dual-write collision on r7, observed on read port 1
    we0 = 1; wr0 = 7; d0 = 32'hAAAA;
    we1 = 1; wr1 = 7; d1 = 32'h5555; ra = {5'd7, 5'd3}; settle();
    chk("coll_same_bp", q_bp[63:32], 32'h5555);
    chk("coll_same_nb", q_nb[63:32], 32'h0);
    tick();
    idle(); settle();
    chk("coll_next_nb", q_nb[63:32], 32'h5555);
    chk("coll_next_bp", q_bp[63:32], 32'h5555);

    // Different addresses commit together
    we0 = 1; wr0 = 10; d0 = 32'h0A0A_0A0A;
    we1 = 1; wr1 = 11; d1 = 32'h0B0B_0B0B;
    tick();
    idle(); ra = {5'd11, 5'd10}; settle();
    chk("dual_r10_nb", q_nb[31:0], 32'h0A0A_0A0A);
    chk("dual_r11_nb", q_nb[63:32], 32'h0B0B_0B0B);

    // Zero register: write and busy-set to r0 are discarded
    we1 = 1; wr1 = 0; d1 = 32'hFFFF_FFFF; set_en = 1; set_addr = 0;
    ra = {5'd0, 5'd0}; settle();
    chk("r0_same_bp", q_bp[31:0], 32'h0);
    tick();
    idle(); settle();
    chk("r0_next_nb", q_nb[31:0], 32'h0);
    chk("r0_busy_nb", busy_nb, 2'b00);
    chk("r0_any_bp", any_bp, 1'b0);
    tick();
    chk("r0_later_bp", q_bp[63:32], 32'h0);

    // Scoreboard: set, set-vs-clear race, lone clear
    set_en = 1; set_addr = 9; ra = {5'd9, 5'd9}; settle();
    chk("set9_no_fwd_nb", busy_nb, 2'b00);
    tick();
    idle(); settle();
    chk("set9_busy_nb", busy_nb, 2'b11);
    chk("set9_any_bp", any_bp, 1'b1);
    we0 = 1; wr0 = 9; d0 = 32'h99; set_en = 1; set_addr = 9;
    tick();
    idle(); settle();
    chk("race_busy_bp", busy_bp, 2'b11);
    chk("race_data_nb", q_nb[31:0], 32'h99);
    we1 = 1; wr1 = 9; d1 = 32'h100; settle();
    chk("clr9_no_fwd_nb", busy_nb[0], 1'b1);
    tick();
    idle(); settle();
    chk("clr9_busy_nb", busy_nb, 2'b00);
    chk("clr9_any_nb", any_nb, 1'b0);
    chk("clr9_data_bp", q_bp[63:32], 32'h100);

    // Reset mid-operation with pending busy bits and an in-flight write
    set_en = 1; set_addr = 2; tick();
    set_en = 1; set_addr = 4; tick();
    idle(); ra = {5'd4, 5'd2}; settle();
    chk("pend_busy_nb", busy_nb, 2'b11);
    rst = 1; we0 = 1; wr0 = 2; d0 = 32'h77; set_en = 1; set_addr = 6;
    tick();
    rst = 0; idle(); settle();
    chk("midrst_r2_nb", q_nb[31:0], 32'h0);
    chk("midrst_r2_bp", q_bp[31:0], 32'h0);
    chk("midrst_any_nb", any_nb, 1'b0);
    chk("midrst_any_bp", any_bp, 1'b0);
    chk("midrst_busy_bp", busy_bp, 2'b00);
    ra = {5'd10, 5'd3}; settle();
    chk("midrst_r3_nb", q_nb[31:0], 32'h0);
    chk("midrst_r10_bp", q_bp[63:32], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
